// File: rtl/nibble_serial_subtractor.sv
// Nibble-serial WIDTH-bit subtractor sequencer around an external 4-bit slice.
// Optional signed overflow flag enabled by NIBBLE_SUB_SIGNED_OVF_EN.
module nibble_serial_subtractor #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startValid,
  output logic             startReady,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       sliceA,
  output logic [3:0]       sliceB,
  output logic             sliceCarryIn,
  input  logic [3:0]       sliceDiff,
  input  logic             sliceCarryOut,
  output logic             resultValid,
  input  logic             resultReady,
  output logic [WIDTH-1:0] diff,
  output logic             borrowOut,
  output logic             overflow
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] diff_q;
  logic             borrow_q;
  logic             accept;
  logic             running;
  logic             last;
  logic             complete;

  // State register; reset aborts any operation in flight
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    state_d     = state_q;
    startReady  = 1'b0;
    resultValid = 1'b0;
    accept      = 1'b0;
    running     = 1'b0;
    last        = 1'b0;
    complete    = 1'b0;
    unique case (state_q)
      IDLE: begin
        startReady = 1'b1;
        accept     = startValid;
        if (startValid) begin
          state_d = RUN;
        end
      end
      RUN: begin
        running = 1'b1;
        last    = (idx_q == LAST_IDX);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end
      end
      DONE: begin
        resultValid = 1'b1;
        complete    = resultReady;
        if (resultReady) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Slice operands come straight from registers and are zero outside RUN
  always_comb begin
    sliceA       = 4'd0;
    sliceB       = 4'd0;
    sliceCarryIn = 1'b0;
    if (running) begin
      sliceA       = a_q[4*idx_q +: 4];
      sliceB       = b_q[4*idx_q +: 4];
      sliceCarryIn = carry_q;
    end
  end

  // Operand capture, nibble index and carry ripple between slice cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b;
      idx_q   <= '0;
      carry_q <= 1'b1;
    end else if (running) begin
      carry_q <= sliceCarryOut;
      idx_q   <= last ? '0 : idx_q + 1'b1;
    end
  end

  // Assemble the difference nibble by nibble; final carry-out gives borrow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      diff_q   <= '0;
      borrow_q <= 1'b0;
    end else if (running) begin
      diff_q[4*idx_q +: 4] <= sliceDiff;
      if (last) begin
        borrow_q <= ~sliceCarryOut;
      end
    end
  end

  assign diff      = diff_q;
  assign borrowOut = borrow_q;

`ifdef NIBBLE_SUB_SIGNED_OVF_EN
  logic ovf_q;

  // Signed overflow: operand signs differ and result sign differs from a
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (running && last) begin
      ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
               (sliceDiff[3] != a_q[WIDTH-1]);
    end
  end

  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

  logic unused_complete;
  assign unused_complete = complete;

endmodule
